// File: rtl/wb_pkg.sv
// Shared types for the Wishbone-classic load/store initiator.
package wb_pkg;

    localparam int WB_XLEN = 32;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_ILL = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [WB_XLEN-1:0] rdata;
        logic               err;
        logic               misalign;
        logic               timeout;
    } resp_t;

    // Lane mask of an access at offset 0; shifted into place by the byte offset.
    function automatic logic [WB_XLEN/8-1:0] lane_mask(input size_e sz);
        case (sz)
            SZ_B:    lane_mask = 4'b0001;
            SZ_H:    lane_mask = 4'b0011;
            SZ_W:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store-side select/shift/misalign and load-side extract/extend.
module lsu_align
    import wb_pkg::*;
(
    input  size_e                st_size_i,
    input  logic [1:0]           st_off_i,
    input  logic [WB_XLEN-1:0]   st_wdata_i,
    output logic [WB_XLEN/8-1:0] st_sel_o,
    output logic [WB_XLEN-1:0]   st_wdata_o,
    output logic                 st_misalign_o,
    input  size_e                ld_size_i,
    input  logic [1:0]           ld_off_i,
    input  logic                 ld_signed_i,
    input  logic [WB_XLEN-1:0]   ld_dat_i,
    output logic [WB_XLEN-1:0]   ld_rdata_o
);

    logic [WB_XLEN-1:0] ld_lane_d;

    assign ld_lane_d = ld_dat_i >> {ld_off_i, 3'b000};

    // Store side: byte selects, lane-shifted data and alignment check.
    always_comb begin
        st_sel_o      = lane_mask(st_size_i) << st_off_i;
        st_wdata_o    = st_wdata_i << {st_off_i, 3'b000};
        st_misalign_o = 1'b1;
        case (st_size_i)
            SZ_B:    st_misalign_o = 1'b0;
            SZ_H:    st_misalign_o = st_off_i[0];
            SZ_W:    st_misalign_o = (st_off_i != 2'b00);
            default: st_misalign_o = 1'b1;
        endcase
    end

    // Load side: the selected lane is already at bit 0; extend it to full width.
    always_comb begin
        case (ld_size_i)
            SZ_B:    ld_rdata_o = {{24{ld_signed_i & ld_lane_d[7]}}, ld_lane_d[7:0]};
            SZ_H:    ld_rdata_o = {{16{ld_signed_i & ld_lane_d[15]}}, ld_lane_d[15:0]};
            SZ_W:    ld_rdata_o = ld_dat_i;
            default: ld_rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/wb_master.sv
// Single-outstanding Wishbone-classic initiator for core load/store requests.
// Optional bus watchdog enabled by defining WB_TIMEOUT_EN.
module wb_master
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              resp_err_o,
    output logic              resp_misalign_o,
    output logic              resp_timeout_o,
    output logic [XLEN-3:0]   wb_adr_o,
    output logic              wb_we_o,
    output logic [XLEN/8-1:0] wb_sel_o,
    output logic [XLEN-1:0]   wb_dat_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic [XLEN-1:0]   wb_dat_i
);

    if (XLEN != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_master: XLEN must be 32 and TIMEOUT_CYCLES at least 1");
    end

    state_e            state_q;
    size_e             size_q;
    logic [1:0]        off_q;
    logic              signed_q;
    resp_t             resp_q;
    logic              resp_valid_q;
    logic [XLEN-3:0]   wb_adr_q;
    logic              wb_we_q;
    logic [XLEN/8-1:0] wb_sel_q;
    logic [XLEN-1:0]   wb_dat_q;
    logic              wb_stb_q;

    logic [XLEN/8-1:0] st_sel_d;
    logic [XLEN-1:0]   st_wdata_d;
    logic              st_misalign_d;
    logic [XLEN-1:0]   ld_rdata_d;
    logic              tmo_hit_d;

`ifdef WB_TIMEOUT_EN
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW > 8) ? TW_RAW : 8;
    logic [TW-1:0] tmo_cnt_q;
    // Counter holds the number of BUS cycles already elapsed, so this is the last permitted one.
    assign tmo_hit_d = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_d = 1'b0;
`endif

    lsu_align u_align (
        .st_size_i     (size_e'(req_size_i)),
        .st_off_i      (req_addr_i[1:0]),
        .st_wdata_i    (req_wdata_i),
        .st_sel_o      (st_sel_d),
        .st_wdata_o    (st_wdata_d),
        .st_misalign_o (st_misalign_d),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_signed_i   (signed_q),
        .ld_dat_i      (wb_dat_i),
        .ld_rdata_o    (ld_rdata_d)
    );

    // Request/bus/response FSM with all outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            size_q       <= SZ_B;
            off_q        <= 2'b00;
            signed_q     <= 1'b0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            wb_adr_q     <= '0;
            wb_we_q      <= 1'b0;
            wb_sel_q     <= 4'b0000;
            wb_dat_q     <= 32'h0000_0000;
            wb_stb_q     <= 1'b0;
`ifdef WB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        if (st_misalign_d) begin
                            resp_q       <= '{rdata: 32'h0000_0000, err: 1'b1,
                                              misalign: 1'b1, timeout: 1'b0};
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            size_q   <= size_e'(req_size_i);
                            off_q    <= req_addr_i[1:0];
                            signed_q <= req_signed_i;
                            wb_adr_q <= req_addr_i[XLEN-1:2];
                            wb_we_q  <= req_we_i;
                            wb_sel_q <= st_sel_d;
                            wb_dat_q <= st_wdata_d;
                            wb_stb_q <= 1'b1;
                            state_q  <= BUS;
`ifdef WB_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end
                    end
                end
                BUS: begin
`ifdef WB_TIMEOUT_EN
                    tmo_cnt_q <= tmo_cnt_q + TW'(1);
`endif
                    if (wb_err_i) begin
                        resp_q       <= '{rdata: 32'h0000_0000, err: 1'b1,
                                          misalign: 1'b0, timeout: 1'b0};
                        resp_valid_q <= 1'b1;
                        wb_stb_q     <= 1'b0;
                        state_q      <= RESP;
                    end else if (wb_ack_i) begin
                        resp_q       <= '{rdata: (wb_we_q ? 32'h0000_0000 : ld_rdata_d),
                                          err: 1'b0, misalign: 1'b0, timeout: 1'b0};
                        resp_valid_q <= 1'b1;
                        wb_stb_q     <= 1'b0;
                        state_q      <= RESP;
                    end else if (tmo_hit_d) begin
                        resp_q       <= '{rdata: 32'h0000_0000, err: 1'b1,
                                          misalign: 1'b0, timeout: 1'b1};
                        resp_valid_q <= 1'b1;
                        wb_stb_q     <= 1'b0;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    wb_stb_q     <= 1'b0;
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o     = (state_q == IDLE);
    assign resp_valid_o    = resp_valid_q;
    assign resp_rdata_o    = resp_q.rdata;
    assign resp_err_o      = resp_q.err;
    assign resp_misalign_o = resp_q.misalign;
    assign resp_timeout_o  = resp_q.timeout;
    assign wb_adr_o        = wb_adr_q;
    assign wb_we_o         = wb_we_q;
    assign wb_sel_o        = wb_sel_q;
    assign wb_dat_o        = wb_dat_q;
    assign wb_stb_o        = wb_stb_q;
    assign wb_cyc_o        = wb_stb_q;

endmodule
